// File: rtl/ant_render_fetch_if.sv
// Memory-side bus of the render fetch stage: cell RAM read port and ant table read port.
interface ant_render_fetch_if #(
    parameter int SIGNAL_bits = 10,
    parameter int ADDR_bits   = 15,
    parameter int ANT_bits    = 6
);
    logic [ADDR_bits-1:0]   cell_addr;
    logic [SIGNAL_bits-1:0] cell_signal;
    logic                   cell_sugar;
    logic [ANT_bits-1:0]    ant_addr;
    logic [7:0]             ant_x;
    logic [6:0]             ant_y;
    logic                   ant_alive;

    // Fetch stage issues addresses and consumes read data.
    modport master (
        output cell_addr, ant_addr,
        input  cell_signal, cell_sugar, ant_x, ant_y, ant_alive
    );

    // Memory side answers addresses with one cycle of latency.
    modport slave (
        input  cell_addr, ant_addr,
        output cell_signal, cell_sugar, ant_x, ant_y, ant_alive
    );
endinterface

// File: rtl/ant_render_fetch.sv
// Pixel-side fetch stage: turns the raster position into ant/sugar/nest/signal
// render flags, and rebuilds a next-line ant occupancy bitmap during each
// horizontal blank so per-pixel ant lookup is a single bit select.
module ant_render_fetch #(
    parameter int SIGNAL_bits = 10,
    parameter int GRID_W      = 160,
    parameter int GRID_H      = 120,
    parameter int CELL_SHIFT  = 2,
    parameter int V_ACTIVE    = 480,
    parameter int N_ANTS      = 64,
    parameter int ANT_bits    = 6,
    parameter int ADDR_bits   = 15,
    parameter int NEST_X0     = 76,
    parameter int NEST_X1     = 83,
    parameter int NEST_Y0     = 56,
    parameter int NEST_Y1     = 63
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic [9:0]             DrawX,
    input  logic [9:0]             DrawY,
    input  logic                   pix_valid,
    input  logic                   hs_start,
    ant_render_fetch_if.master     mem,
    output logic                   renderAnt,
    output logic                   renderSugar,
    output logic                   renderNest,
    output logic [SIGNAL_bits-1:0] renderSignal,
    output logic                   render_valid,
    output logic                   scan_overrun
);
    localparam int CW = 10 - CELL_SHIFT;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SCAN   = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;
    localparam logic [1:0] ST_COMMIT = 2'd3;

    logic [CW-1:0]          cx, cy;
    logic                   nest_hit;
    logic [CW-1:0]          cx1_q, cx1_d;
    logic                   v1_q, v1_d;
    logic                   nest1_q, nest1_d;
    logic                   ant2_q, ant2_d;
    logic                   sugar2_q, sugar2_d;
    logic                   nest2_q, nest2_d;
    logic [SIGNAL_bits-1:0] signal2_q, signal2_d;
    logic                   v2_q, v2_d;

    logic [1:0]             state_q, state_d;
    logic [ANT_bits-1:0]    ant_addr_q, ant_addr_d;
    logic [6:0]             trow_q, trow_d;
    logic [GRID_W-1:0]      build_map_q, build_map_d;
    logic [GRID_W-1:0]      disp_map_q, disp_map_d;
    logic                   overrun_q, overrun_d;
    logic [10:0]            next_line;
    logic [9:0]             target_line;
    logic                   ant_hit;

    // Cell coordinates, RAM address and nest test for the current pixel.
    always_comb begin
        cx = CW'(DrawX >> CELL_SHIFT);
        cy = CW'(DrawY >> CELL_SHIFT);
        mem.cell_addr = ADDR_bits'(cy) * ADDR_bits'(GRID_W) + ADDR_bits'(cx);
        nest_hit = (cx >= CW'(NEST_X0)) && (cx <= CW'(NEST_X1)) &&
                   (cy >= CW'(NEST_Y0)) && (cy <= CW'(NEST_Y1));
    end

    // Two-stage pixel pipeline; stage 2 meets the RAM data returned for stage 1.
    always_comb begin
        cx1_d   = cx;
        v1_d    = pix_valid;
        nest1_d = nest_hit;
        v2_d    = v1_q;
        if (v1_q) begin
            signal2_d = mem.cell_signal;
            sugar2_d  = mem.cell_sugar;
            nest2_d   = nest1_q;
            ant2_d    = (cx1_q < CW'(GRID_W)) ? disp_map_q[cx1_q] : 1'b0;
        end else begin
            signal2_d = '0;
            sugar2_d  = 1'b0;
            nest2_d   = 1'b0;
            ant2_d    = 1'b0;
        end
    end

    // Pixel pipeline registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cx1_q     <= '0;
            v1_q      <= 1'b0;
            nest1_q   <= 1'b0;
            ant2_q    <= 1'b0;
            sugar2_q  <= 1'b0;
            nest2_q   <= 1'b0;
            signal2_q <= '0;
            v2_q      <= 1'b0;
        end else begin
            cx1_q     <= cx1_d;
            v1_q      <= v1_d;
            nest1_q   <= nest1_d;
            ant2_q    <= ant2_d;
            sugar2_q  <= sugar2_d;
            nest2_q   <= nest2_d;
            signal2_q <= signal2_d;
            v2_q      <= v2_d;
        end
    end

    // Ant scan FSM: reads the table during horizontal blank and commits the
    // finished row bitmap in one step so the active line never sees a partial map.
    always_comb begin
        state_d     = state_q;
        ant_addr_d  = ant_addr_q;
        trow_d      = trow_q;
        build_map_d = build_map_q;
        disp_map_d  = disp_map_q;
        overrun_d   = overrun_q;

        next_line   = {1'b0, DrawY} + 11'd1;
        target_line = (next_line >= 11'(V_ACTIVE)) ? 10'd0 : next_line[9:0];
        ant_hit     = mem.ant_alive && (mem.ant_y == trow_q) &&
                      (mem.ant_x < 8'(GRID_W)) && (mem.ant_y < 7'(GRID_H));

        if (hs_start) begin
            // A new blank always wins: an unfinished scan is abandoned, never committed.
            if (state_q != ST_IDLE) overrun_d = 1'b1;
            trow_d      = 7'(target_line >> CELL_SHIFT);
            build_map_d = '0;
            ant_addr_d  = '0;
            state_d     = ST_SCAN;
        end else begin
            case (state_q)
                ST_SCAN: begin
                    // Address 0 has no data behind it yet; from then on the bus
                    // carries the entry issued one cycle earlier.
                    if ((ant_addr_q != '0) && ant_hit) build_map_d[mem.ant_x] = 1'b1;
                    if (ant_addr_q == ANT_bits'(N_ANTS - 1)) state_d = ST_DRAIN;
                    else ant_addr_d = ant_addr_q + 1'b1;
                end
                ST_DRAIN: begin
                    if (ant_hit) build_map_d[mem.ant_x] = 1'b1;
                    state_d = ST_COMMIT;
                end
                ST_COMMIT: begin
                    disp_map_d = build_map_q;
                    state_d    = ST_IDLE;
                end
                default: ;
            endcase
        end
    end

    // Scan FSM registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            ant_addr_q  <= '0;
            trow_q      <= '0;
            build_map_q <= '0;
            disp_map_q  <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ant_addr_q  <= ant_addr_d;
            trow_q      <= trow_d;
            build_map_q <= build_map_d;
            disp_map_q  <= disp_map_d;
            overrun_q   <= overrun_d;
        end
    end

    assign mem.ant_addr  = ant_addr_q;
    assign renderAnt     = ant2_q;
    assign renderSugar   = sugar2_q;
    assign renderNest    = nest2_q;
    assign renderSignal  = signal2_q;
    assign render_valid  = v2_q;
    assign scan_overrun  = overrun_q;
endmodule

// File: tb/tb_ant_render_fetch.sv
// Directed bench for ant_render_fetch with behavioural cell RAM / ant table
// and a latency-2 scoreboard of expected render outputs.
module tb_ant_render_fetch;
    logic       Clk = 1'b0;
    logic       Reset;
    logic [9:0] DrawX, DrawY;
    logic       pix_valid, hs_start;
    logic       renderAnt, renderSugar, renderNest, render_valid, scan_overrun;
    logic [9:0] renderSignal;

    ant_render_fetch_if #(.SIGNAL_bits(10), .ADDR_bits(15), .ANT_bits(6)) bus ();

    ant_render_fetch #(
        .SIGNAL_bits(10), .GRID_W(160), .GRID_H(120), .CELL_SHIFT(2),
        .V_ACTIVE(480), .N_ANTS(64), .ANT_bits(6), .ADDR_bits(15),
        .NEST_X0(76), .NEST_X1(83), .NEST_Y0(56), .NEST_Y1(63)
    ) dut (
        .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY),
        .pix_valid(pix_valid), .hs_start(hs_start), .mem(bus),
        .renderAnt(renderAnt), .renderSugar(renderSugar), .renderNest(renderNest),
        .renderSignal(renderSignal), .render_valid(render_valid),
        .scan_overrun(scan_overrun)
    );

    always #5 Clk = ~Clk;

    logic [7:0] ax [64];
    logic [6:0] ay [64];
    logic       al [64];

    function automatic logic [9:0] sig_fn(input logic [14:0] a);
        if (a == 15'd490) return 10'd300;
        return 10'(a * 15'd13 + 15'd7);
    endfunction

    function automatic logic sug_fn(input logic [14:0] a);
        if (a == 15'd490) return 1'b1;
        return a[2] ^ a[5];
    endfunction

    // Memory models with one cycle read latency.
    always @(posedge Clk) begin
        bus.cell_signal <= sig_fn(bus.cell_addr);
        bus.cell_sugar  <= sug_fn(bus.cell_addr);
        bus.ant_x       <= ax[bus.ant_addr];
        bus.ant_y       <= ay[bus.ant_addr];
        bus.ant_alive   <= al[bus.ant_addr];
    end

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       v;
        logic       ant;
        logic       sug;
        logic       nest;
        logic [9:0] sig;
    } exp_t;

    exp_t         q[$];
    int           n_checks = 0;
    int           n_pass   = 0;
    logic [159:0] model_map;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic exp_t model_pix(input int x, input int y, input logic v);
        exp_t e;
        int   cx, cy;
        logic [14:0] a;
        e = '0;
        e.x = 10'(x);
        e.y = 10'(y);
        if (!v) return e;
        cx = x / 4;
        cy = y / 4;
        a = 15'(cy * 160 + cx);
        e.v    = 1'b1;
        e.ant  = model_map[cx];
        e.sug  = sug_fn(a);
        e.nest = (cx >= 76) && (cx <= 83) && (cy >= 56) && (cy <= 63);
        e.sig  = sig_fn(a);
        return e;
    endfunction

    // One clock: compare the pixel driven two cycles ago, then drive the next one.
    task automatic tick(input int x, input int y, input logic v, input logic hs);
        exp_t e;
        @(negedge Clk);
        if (q.size() == 2) begin
            e = q.pop_front();
            check($sformatf("pix(%0d,%0d)", e.x, e.y),
                  32'({render_valid, renderAnt, renderSugar, renderNest, renderSignal}),
                  32'({e.v, e.ant, e.sug, e.nest, e.sig}));
        end
        DrawX     = 10'(x);
        DrawY     = 10'(y);
        pix_valid = v;
        hs_start  = hs;
        q.push_back(model_pix(x, y, v));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 1'b0, 1'b0);
    endtask

    task automatic sweep(input int y, input int x0, input int x1);
        for (int x = x0; x <= x1; x++) tick(x, y, 1'b1, 1'b0);
    endtask

    task automatic clear_ants();
        for (int i = 0; i < 64; i++) begin
            ax[i] = 8'd0;
            ay[i] = 7'd0;
            al[i] = 1'b0;
        end
    endtask

    // Asynchronous reset while the pixel stream is still running.
    task automatic async_reset(input string tag);
        #2 Reset = 1'b1;
        #1;
        check({tag, "_outs"},
              32'({renderAnt, renderSugar, renderNest, renderSignal, render_valid}), 32'd0);
        check({tag, "_overrun"}, 32'(scan_overrun), 32'd0);
        check({tag, "_ant_addr"}, 32'(bus.ant_addr), 32'd0);
        q.delete();
        model_map = '0;
        @(negedge Clk);
        pix_valid = 1'b0;
        hs_start  = 1'b0;
        Reset     = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1; DrawX = '0; DrawY = '0; pix_valid = 1'b0; hs_start = 1'b0;
        model_map = '0;
        clear_ants();
        repeat (3) @(negedge Clk);
        check("rst_outs", 32'({renderAnt, renderSugar, renderNest, renderSignal, render_valid}), 32'd0);
        check("rst_overrun", 32'(scan_overrun), 32'd0);
        check("rst_ant_addr", 32'(bus.ant_addr), 32'd0);
        Reset = 1'b0;

        // Pipeline data: cell (10,3), nest corners and just-outside pixels.
        tick(40, 12, 1'b1, 1'b0);
        #1 check("cell_addr_490", 32'(bus.cell_addr), 32'd490);
        tick(310, 230, 1'b1, 1'b0);
        #1 check("cell_addr_nest", 32'(bus.cell_addr), 32'd9197);
        tick(304, 224, 1'b1, 1'b0);
        tick(335, 255, 1'b1, 1'b0);
        tick(336, 255, 1'b1, 1'b0);
        tick(303, 240, 1'b1, 1'b0);
        tick(320, 256, 1'b1, 1'b0);
        tick(639, 479, 1'b1, 1'b0);
        idle(2);

        // Ant hit: ant 5 at (5,10), line 39 blank builds row 10.
        ax[5] = 8'd5; ay[5] = 7'd10; al[5] = 1'b1;
        tick(0, 39, 1'b0, 1'b1);
        idle(66);
        check("ant_addr_end", 32'(bus.ant_addr), 32'd63);
        model_map = '0; model_map[5] = 1'b1;
        sweep(40, 0, 39);

        // Dead ant.
        al[5] = 1'b0;
        tick(0, 39, 1'b0, 1'b1);
        idle(66);
        model_map = '0;
        sweep(40, 0, 39);

        // Out-of-range column.
        ax[5] = 8'd200; al[5] = 1'b1;
        tick(0, 39, 1'b0, 1'b1);
        idle(66);
        model_map = '0;
        sweep(40, 0, 39);

        // Duplicates, first and last table entries, neighbouring rows.
        clear_ants();
        ax[5]  = 8'd5; ay[5]  = 7'd10; al[5]  = 1'b1;
        ax[9]  = 8'd5; ay[9]  = 7'd10; al[9]  = 1'b1;
        ax[0]  = 8'd0; ay[0]  = 7'd10; al[0]  = 1'b1;
        ax[63] = 8'd7; ay[63] = 7'd10; al[63] = 1'b1;
        ax[20] = 8'd6; ay[20] = 7'd9;  al[20] = 1'b1;
        ax[21] = 8'd9; ay[21] = 7'd11; al[21] = 1'b1;
        tick(0, 39, 1'b0, 1'b1);
        idle(66);
        model_map = '0; model_map[0] = 1'b1; model_map[5] = 1'b1; model_map[7] = 1'b1;
        sweep(40, 0, 39);

        // Wrap from the last active line and from vertical blank to row 0.
        clear_ants();
        ax[0] = 8'd3; ay[0] = 7'd0; al[0] = 1'b1;
        ax[1] = 8'd2; ay[1] = 7'd1; al[1] = 1'b1;
        tick(0, 479, 1'b0, 1'b1);
        idle(66);
        model_map = '0; model_map[3] = 1'b1;
        sweep(0, 0, 23);
        ax[0] = 8'd4;
        tick(0, 524, 1'b0, 1'b1);
        idle(66);
        model_map = '0; model_map[4] = 1'b1;
        sweep(0, 0, 23);

        // Overrun: second blank 10 cycles into the first scan.
        ax[2] = 8'd8;  ay[2] = 7'd1; al[2] = 1'b1;
        ax[3] = 8'd12; ay[3] = 7'd2; al[3] = 1'b1;
        tick(0, 3, 1'b0, 1'b1);
        idle(9);
        check("overrun_before", 32'(scan_overrun), 32'd0);
        tick(0, 7, 1'b0, 1'b1);
        sweep(0, 0, 0);
        check("overrun_set", 32'(scan_overrun), 32'd1);
        sweep(0, 1, 59);
        idle(6);
        model_map = '0; model_map[12] = 1'b1;
        sweep(8, 0, 59);
        check("overrun_sticky", 32'(scan_overrun), 32'd1);

        // Reset mid-scan with pixels in flight: nothing commits afterwards.
        ax[5] = 8'd5; ay[5] = 7'd10; al[5] = 1'b1;
        tick(0, 39, 1'b0, 1'b1);
        sweep(0, 0, 4);
        async_reset("rst_mid");
        idle(70);
        check("ant_addr_after_rst", 32'(bus.ant_addr), 32'd0);
        sweep(40, 0, 39);
        sweep(8, 44, 55);
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/ant_render_fetch.md
Name: ant_render_fetch

Overview:
- Pixel-side fetch stage directly upstream of the colour mapper. Turns the VGA raster position (DrawX/DrawY) into per-pixel render flags: renderAnt, renderSugar, renderNest and renderSignal.
- Reads the per-cell signal/sugar RAM once per pixel.
- Tests a fixed nest square.
- During each horizontal blank, scans the ant table and builds a next-line ant occupancy bitmap, so ant lookup per pixel is a single bit select.

Parameters:
- SIGNAL_bits, 10, width of the per-cell chemical signal.
- GRID_W, 160, grid columns.
- GRID_H, 120, grid rows.
- CELL_SHIFT, 2, log2 of pixels per cell edge.
- V_ACTIVE, 480, active display lines.
- N_ANTS, 64, ant table entries.
- ANT_bits, 6, log2(N_ANTS).
- ADDR_bits, 15, cell RAM address width.
- NEST_X0 / NEST_X1 / NEST_Y0 / NEST_Y1, 76 / 83 / 56 / 63, inclusive nest cell rectangle.

Ports:
- Clk, in, 1: system clock.
- Reset, in, 1: asynchronous, active-high reset.
- DrawX, in, 10: current pixel column.
- DrawY, in, 10: current pixel line.
- pix_valid, in, 1: DrawX/DrawY lie in the active area.
- hs_start, in, 1: one-cycle pulse at the start of horizontal blank for line DrawY.
- cell_addr, out, ADDR_bits: combinational cell RAM address.
- cell_signal, in, SIGNAL_bits: RAM signal data, returned 1 cycle after address.
- cell_sugar, in, 1: RAM sugar bit, same timing as cell_signal.
- ant_addr, out, ANT_bits: registered ant table address.
- ant_x, in, 8: ant column, returned 1 cycle after ant_addr.
- ant_y, in, 7: ant row, same timing as ant_x.
- ant_alive, in, 1: ant entry valid, same timing as ant_x.
- renderAnt, out, 1: pixel lies in an ant cell.
- renderSugar, out, 1: pixel lies in a sugar cell.
- renderNest, out, 1: pixel lies in the nest rectangle.
- renderSignal, out, SIGNAL_bits: signal value of the cell.
- render_valid, out, 1: pix_valid delayed 2 cycles.
- scan_overrun, out, 1: sticky; a scan was restarted before it committed.

Behaviour:

Reset (async):
- All render outputs 0, render_valid 0, ant_addr 0, scan_overrun 0.
- Both ant bitmaps cleared. FSM in IDLE.

Pixel pipeline (latency 2):
- Cell coordinates: cx = DrawX >> CELL_SHIFT, cy = DrawY >> CELL_SHIFT.
- cell_addr = cy*GRID_W + cx, computed combinationally as (cy<<7)+(cy<<5)+cx for the default grid, truncated to ADDR_bits.
- Stage 1 registers cx, pix_valid and nest_hit, where nest_hit = cx in [NEST_X0,NEST_X1] and cy in [NEST_Y0,NEST_Y1].
- Stage 2 registers:
  - renderSignal <= cell_signal.
  - renderSugar <= cell_sugar.
  - renderNest <= nest_hit.
  - renderAnt <= disp_map[cx].
  - render_valid <= stage-1 valid.
- When stage-1 valid is 0, stage 2 loads all render flags and renderSignal as 0.
- Flags are independent; several may be 1 at once. Priority is resolved downstream.

Ant scan FSM, states IDLE, SCAN, DRAIN, COMMIT:
- IDLE, on hs_start:
  - target_line = DrawY+1, or 0 if DrawY+1 >= V_ACTIVE.
  - trow = target_line >> CELL_SHIFT.
  - Clear build_map; ant_addr <= 0; go to SCAN.
- SCAN:
  - Each cycle, ant_addr increments.
  - Data returned for the previous address is processed: if ant_alive, ant_y == trow and ant_x < GRID_W, set build_map[ant_x].
  - After issuing N_ANTS-1, go to DRAIN.
- DRAIN: process the final entry, then go to COMMIT.
- COMMIT: disp_map <= build_map, then go to IDLE.
- Busy time: N_ANTS+2 cycles after the hs_start edge. disp_map is unchanged outside COMMIT, so the active line always shows a consistent bitmap.
- hs_start while not IDLE: set scan_overrun, discard build_map, restart from the IDLE actions using the new DrawY. disp_map keeps its old value.
- Ants with ant_x >= GRID_W or ant_y >= GRID_H never set a bit.
- Duplicate ants in one cell just set the same bit.
- Reset mid-scan: IDLE, maps cleared, no commit.
- ant_addr wraps modulo N_ANTS only through restart; it never exceeds N_ANTS-1.

Test Plan:
- Reset mid-line: assert Reset with pix_valid=1 -> all outputs 0 immediately (async), render_valid 0; after release, first render_valid appears 2 cycles after pix_valid.
- Ant hit: ant 5 = (x=5, y=10, alive), all others dead; hs_start with DrawY=39; after 66 cycles sweep DrawX 0..39 on DrawY=40 -> renderAnt=1 exactly for DrawX 20..23, each 2 cycles after the pixel.
- Dead/out-of-range: same as the ant-hit case with alive=0, then with x=200 -> renderAnt never 1; same-cell duplicates -> still a single set bit.
- Pipeline data: cell (10,3) RAM holds signal=300, sugar=1; DrawX=40, DrawY=12 -> cell_addr=490; 2 cycles later renderSignal=300, renderSugar=1, renderNest=0. Pixel (310,230) -> renderNest=1.
- Wrap: hs_start with DrawY=479 and an ant at y=0 -> bitmap built for row 0; DrawY=524 also targets row 0.
- Overrun: second hs_start 10 cycles after the first -> scan_overrun=1 and sticky; disp_map unchanged until the restarted scan commits N_ANTS+2 cycles later.
